ssio_ddr_deser_align: RTL

SSIO_DDR_DESER_ALIGN -- requirements
Module: ssio_ddr_deser_align

---
 rtl/ssio_ddr_deser_align.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ssio_ddr_deser_align.sv
// rtl/ssio_ddr_deser_align.sv - DDR lane deserializer with per-lane bit-slip word alignment
// Define SSIO_DESER_SLIP_CNT_EN to build the per-lane saturating slip counters.
module ssio_ddr_deser_align #(
  parameter int                 LANES         = 4,
  parameter int                 DESER         = 4,
  parameter logic [2*DESER-1:0] TRAIN_PATTERN = 8'h5C,
  parameter int                 LOCK_COUNT    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [LANES-1:0]           in_q1,
  input  logic [LANES-1:0]           in_q2,
  input  logic                       train,
  output logic [LANES*2*DESER-1:0]   out_data,
  output logic                       out_valid,
  output logic [LANES-1:0]           lane_locked,
  output logic                       all_locked,
  output logic [LANES*4-1:0]         align_offset,
  output logic [LANES*8-1:0]         slip_count
);
  localparam int W = 2 * DESER;

  typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

  logic [2:0]         r_phase;
  logic               w_strobe;
  state_t             r_state     [LANES];
  state_t             w_state_nxt [LANES];
  logic [3:0]         r_offset     [LANES];
  logic [3:0]         w_offset_nxt [LANES];
  logic [7:0]         r_match      [LANES];
  logic [7:0]         w_match_nxt  [LANES];
  logic [2*W-1:0]     r_hist [LANES];
  logic [2*W+1:0]     w_hist [LANES];
  logic [W-1:0]       w_word [LANES];
  logic [LANES-1:0]   r_settle;
  logic [LANES-1:0]   w_settle_nxt;
  logic [LANES-1:0]   w_slip;
  logic [LANES-1:0]   w_locked_nxt;
  logic [LANES*W-1:0] r_out_data;
  logic               r_out_valid;
  logic [LANES-1:0]   r_lane_locked;
  logic               r_all_locked;

  assign w_strobe = (r_phase == 3'(DESER - 1));

  // The word includes this cycle's pair so a strobe sees a complete word right after reset.
  always_comb begin
    for (int n = 0; n < LANES; n++) begin
      w_hist[n]       = {r_hist[n], in_q1[n], in_q2[n]};
      w_word[n]       = W'(w_hist[n] >> r_offset[n]);
      w_state_nxt[n]  = r_state[n];
      w_offset_nxt[n] = r_offset[n];
      w_match_nxt[n]  = r_match[n];
      w_settle_nxt[n] = r_settle[n];
      w_slip[n]       = 1'b0;
      if (train) begin
        w_state_nxt[n]  = S_SEARCH;
        w_match_nxt[n]  = 8'd0;
        w_settle_nxt[n] = 1'b0;
      end else if (w_strobe && r_settle[n]) begin
        w_settle_nxt[n] = 1'b0;
      end else if (w_strobe) begin
        case (r_state[n])
          S_SEARCH: begin
            if (w_word[n] == TRAIN_PATTERN) begin
              w_match_nxt[n] = 8'd1;
              if (LOCK_COUNT == 1) w_state_nxt[n] = S_LOCKED;
              else                 w_state_nxt[n] = S_CHECK;
            end else begin
              w_slip[n] = 1'b1;
            end
          end
          S_CHECK: begin
            if (w_word[n] == TRAIN_PATTERN) begin
              w_match_nxt[n] = r_match[n] + 8'd1;
              if (r_match[n] + 8'd1 == 8'(LOCK_COUNT)) w_state_nxt[n] = S_LOCKED;
            end else begin
              w_slip[n]      = 1'b1;
              w_state_nxt[n] = S_SEARCH;
              w_match_nxt[n] = 8'd0;
            end
          end
          default: ;
        endcase
      end
      if (w_slip[n]) begin
        w_offset_nxt[n] = (r_offset[n] == 4'(W - 1)) ? 4'd0 : r_offset[n] + 4'd1;
        w_settle_nxt[n] = 1'b1;
      end
      w_locked_nxt[n] = (w_state_nxt[n] == S_LOCKED);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase       <= 3'd0;
      r_settle      <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
      r_lane_locked <= '0;
      r_all_locked  <= 1'b0;
      for (int n = 0; n < LANES; n++) begin
        r_state[n]  <= S_SEARCH;
        r_offset[n] <= 4'd0;
        r_match[n]  <= 8'd0;
        r_hist[n]   <= '0;
      end
    end else begin
      r_phase       <= w_strobe ? 3'd0 : r_phase + 3'd1;
      r_settle      <= w_settle_nxt;
      r_lane_locked <= w_locked_nxt;
      r_all_locked  <= &w_locked_nxt;
      r_out_valid   <= w_strobe & r_all_locked & ~train;
      for (int n = 0; n < LANES; n++) begin
        r_state[n]  <= w_state_nxt[n];
        r_offset[n] <= w_offset_nxt[n];
        r_match[n]  <= w_match_nxt[n];
        r_hist[n]   <= w_hist[n][2*W-1:0];
        if (w_strobe) r_out_data[n*W +: W] <= w_word[n];
      end
    end
  end

`ifdef SSIO_DESER_SLIP_CNT_EN
  logic [7:0] r_slip_cnt [LANES];

  // Survives train on purpose: it records link quality since the last reset.
  always_ff @(posedge clk) begin
    for (int n = 0; n < LANES; n++) begin
      if (rst)                                     r_slip_cnt[n] <= 8'd0;
      else if (w_slip[n] && r_slip_cnt[n] != 8'hFF) r_slip_cnt[n] <= r_slip_cnt[n] + 8'd1;
    end
  end

  always_comb begin
    slip_count = '0;
    for (int n = 0; n < LANES; n++) slip_count[n*8 +: 8] = r_slip_cnt[n];
  end
`else
  assign slip_count = '0;
`endif

  always_comb begin
    align_offset = '0;
    for (int n = 0; n < LANES; n++) align_offset[n*4 +: 4] = r_offset[n];
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign lane_locked = r_lane_locked;
  assign all_locked  = r_all_locked;
endmodule
